// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit Wishbone-style memory slave port between NM masters.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int NM    = 2,
    parameter int ADRW  = 18,
    parameter int TMO_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NM-1:0]       m_stb_i,
    input  logic [NM-1:0]       m_we_i,
    input  logic [2*NM-1:0]     m_sel_i,
    input  logic [NM*ADRW-1:0]  m_adr_i,
    input  logic [16*NM-1:0]    m_dat_i,
    output logic [15:0]         m_dat_o,
    output logic [NM-1:0]       m_ack_o,
    output logic [NM-1:0]       m_busy_o,
    output logic [NM-1:0]       m_err_o,
    output logic [NM-1:0]       grant_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [1:0]          s_sel_o,
    output logic [ADRW-1:0]     s_adr_o,
    output logic [15:0]         s_dat_o,
    input  logic [15:0]         s_dat_i,
    input  logic                s_ack_i
);

    localparam int PW = (NM > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic [NM-1:0]   win_vec;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_cnt;
    logic [NM-1:0]    err_q;
    assign m_err_o = err_q;
`else
    assign m_err_o = '0;
`endif

    // Winner is the requester at the smallest rotational distance past the last grant.
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    always_comb begin
        int best_d;
        int d;
        best_d  = NM;
        d       = 0;
        win_idx = '0;
        win_vec = '0;
        for (int i = 0; i < NM; i++) begin
            if (m_stb_i[i]) begin
                d = i - int'(ptr) - 1;
                if (d < 0) d = d + NM;
                if (d < best_d) begin
                    best_d  = d;
                    win_idx = PW'(i);
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            win_vec[i] = (|m_stb_i) && (win_idx == PW'(i));
        end
    end

    // Slave-side request mux; grant_o is one-hot or zero, so an AND-OR mux suffices.
    always_comb begin
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_o[i]) begin
                s_stb_o = s_stb_o | m_stb_i[i];
                s_we_o  = s_we_o  | m_we_i[i];
                s_sel_o = s_sel_o | m_sel_i[2*i +: 2];
                s_adr_o = s_adr_o | m_adr_i[i*ADRW +: ADRW];
                s_dat_o = s_dat_o | m_dat_i[16*i +: 16];
            end
        end
    end

    assign m_ack_o = grant_o & m_stb_i & {NM{s_ack_i}};
    assign m_dat_o = s_dat_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            grant_o  <= '0;
            ptr      <= PW'(NM - 1);
            s_cyc_o  <= 1'b0;
            m_busy_o <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    m_busy_o <= '0;
                    if (|m_stb_i) begin
                        grant_o  <= win_vec;
                        ptr      <= win_idx;
                        s_cyc_o  <= 1'b1;
                        m_busy_o <= ~win_vec;
                        state    <= GRANT;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!s_stb_o) begin
                        grant_o  <= '0;
                        s_cyc_o  <= 1'b0;
                        m_busy_o <= '1;
                        state    <= RELEASE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (s_ack_i) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Stalled too long: flag the owner and free the bus without an ack.
                        err_q    <= grant_o;
                        tmo_cnt  <= '0;
                        grant_o  <= '0;
                        s_cyc_o  <= 1'b0;
                        m_busy_o <= '1;
                        state    <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    m_busy_o <= '0;
                    state    <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_q    <= '0;
`endif
                end
                default: begin
                    grant_o  <= '0;
                    s_cyc_o  <= 1'b0;
                    m_busy_o <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one 16-bit Wishbone-style memory slave port (SRAM/SDRAM controller side) between NM masters, e.g. the CPU 32-to-16 bridge and a DMA/video fetch engine.
- Grants are round-robin. The owning master keeps the bus for as long as it holds stb, so multi-beat sequences (low half-word then high half-word) are never split.
- Per-master busy outputs drive each master's memory-side cyc/busy input. A master therefore does not start a new request while another master owns the bus.

Parameters:
- NM, 2, number of masters (2..4).
- ADRW, 18, half-word address width.
- TMO_W, 8, width of the ack watchdog counter (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- m_stb_i  in  NM  per-master strobe; held high for the whole owned sequence
- m_we_i  in  NM  per-master write enable
- m_sel_i  in  2*NM  per-master byte selects, master i at [2i+1:2i]
- m_adr_i  in  NM*ADRW  per-master address
- m_dat_i  in  16*NM  per-master write data
- m_dat_o  out  16  read data, broadcast to all masters
- m_ack_o  out  NM  per-master ack
- m_busy_o  out  NM  bus owned by another master, or turnaround in progress
- m_err_o  out  NM  timeout error pulse; tied 0 without the optional feature
- grant_o  out  NM  one-hot current owner; 0 when no master owns the bus
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  2  slave byte selects
- s_adr_o  out  ADRW  slave address
- s_dat_o  out  16  slave write data
- s_dat_i  in  16  slave read data
- s_ack_i  in  1  slave ack

Behaviour:
- Reset (async assert, sync deassert): state IDLE, grant_o=0, last-grant pointer = NM-1, s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_busy_o=0, m_err_o=0.
- Reset asserted mid-transfer aborts immediately; the in-flight master gets no ack.
- State IDLE:
  - s_cyc_o=0, all m_busy_o=0.
  - If any m_stb_i is high at the clock edge, select the winner by round-robin, searching from pointer+1 upward and wrapping.
  - Register the winner into grant_o, update the pointer, go to GRANT.
  - Latency: stb sampled at edge n gives grant_o and s_cyc_o high after edge n.
- State GRANT:
  - s_cyc_o=1.
  - s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o are a combinational mux of the granted master's inputs; s_stb_o = m_stb_i[g].
  - m_ack_o[g] = s_ack_i & m_stb_i[g]. A stray ack while stb is low is ignored.
  - m_dat_o = s_dat_i at all times.
  - m_busy_o[i] = ~grant_o[i].
  - When m_stb_i[g] is sampled low, go to RELEASE. If ack and the stb drop coincide, the ack is still forwarded in that cycle.
- State RELEASE:
  - One turnaround cycle: s_cyc_o=0, grant_o=0, all m_busy_o=1. Then go to IDLE.
  - Minimum gap between owners is 2 cycles (RELEASE plus the IDLE arbitration cycle).
- Non-granted masters holding stb stay pending and never see ack. They are served in round-robin order; no master is starved while others keep releasing.
- A single requester re-requesting repeatedly is re-granted each time; the pointer skips idle masters.
- All control outputs other than the slave-side mux and the ack/dat passthrough are registered.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A TMO_W-bit counter clears on grant and on each forwarded ack.
  - It increments each GRANT cycle with s_stb_o=1 & s_ack_i=0.
  - On reaching 2^TMO_W-1: pulse m_err_o[g] for 1 cycle (no ack) and force RELEASE. The master must then drop stb.
- When undefined: no counter, m_err_o=0, and GRANT waits for ack indefinitely.

Test Plan:
- Reset then idle, NM=2 → s_cyc_o=0, grant_o=0, m_busy_o=2'b00.
- Master 0: stb high with adr=0x00010, we=0, slave acks on 2nd cycle with s_dat_i=0xBEEF, then a 2nd beat at adr 0x00011 acked with 0x1234, then stb drops.
  - grant_o=2'b01 one cycle after stb.
  - Two m_ack_o[0] pulses with m_dat_o=0xBEEF and 0x1234.
  - Single continuous s_cyc_o; m_busy_o[1]=1 throughout.
  - RELEASE for one cycle, then IDLE.
- Both masters raise stb in the same IDLE cycle from reset → master 0 granted first. After it releases, master 1 is granted 2 cycles later with no ack to master 1 in between. Next simultaneous request → master 0.
- Master 1 write, sel=2'b10, dat=0xA5A5 → s_sel_o=2'b10, s_we_o=1, s_dat_o=0xA5A5 while granted; m_ack_o[0] never asserts.
- rst_n_i pulsed low mid-GRANT, before ack → s_cyc_o and grant_o drop asynchronously; no m_ack_o.
- With MEM_ARB_TIMEOUT_EN and TMO_W=4: master 0 granted, slave never acks → m_err_o[0] pulses after 15 stalled cycles, then RELEASE.
